uart_pixel_packer: RTL and testbench

Synchronous byte-to-pixel packer between the UART bridge (byte + write strobe) and the two SDRAM frame-buffer write ports. Each group of three bytes (B, G, R) becomes one 30-bit pixel, emitted as two 16-bit words in the split frame-buffer format. All logic runs on the system clock; the UART strobe is never used as a clock. Frame position, pixel count, overflow and timeout status are tracked for display and debug.

---
 rtl/uart_pixel_packer.sv | 192 +++++++++++++++++++
 tb/tb_uart_pixel_packer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pixel_packer.sv
// Packs UART bytes (B, G, R) into one 30-bit pixel written as two 16-bit frame-buffer words.
// Optional idle timeout for partial pixels is enabled with `define PACKER_TIMEOUT_EN.
module uart_pixel_packer #(
    parameter int unsigned HRes       = 640,
    parameter int unsigned VRes       = 480,
    parameter int unsigned TimeoutCyc = 50000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  data_i,
    input  logic        write_i,
    input  logic        resync_i,
    input  logic        wr_full_i,
    output logic [15:0] wr1_data_o,
    output logic [15:0] wr2_data_o,
    output logic        wr_o,
    output logic [31:0] pix_cnt_o,
    output logic [15:0] frame_cnt_o,
    output logic        frame_done_o,
    output logic        overflow_o,
    output logic        timeout_o
);

    localparam int unsigned FrameSize = HRes * VRes;
    localparam int unsigned PosW      = (FrameSize > 1) ? $clog2(FrameSize) : 1;
    localparam logic [PosW-1:0] PosLast = PosW'(FrameSize - 1);

    typedef enum logic [1:0] {StWaitB, StWaitG, StWaitR} phase_e;

    phase_e            phase_q, phase_d;
    logic              write_q;
    logic [7:0]        b_q, b_d, g_q, g_d;
    logic              pend_q, pend_d;
    logic [15:0]       wr1_q, wr1_d, wr2_q, wr2_d;
    logic [PosW-1:0]   pos_q, pos_d;
    logic [31:0]       pix_cnt_q, pix_cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              overflow_q, overflow_d;

    logic              accept;
    logic              r_done;
    logic              load_pix;
    logic              drop_pix;
    logic              timeout_fire;
    logic [9:0]        b10, g10, r10;

    // Rising edge of the level strobe; a resync in the same cycle swallows the byte.
    assign accept   = write_i & ~write_q & ~resync_i;
    assign r_done   = accept & (phase_q == StWaitR);
    assign load_pix = r_done & (~pend_q | wr_o);
    assign drop_pix = r_done & pend_q & ~wr_o;

    assign b10 = {b_q, 2'b00};
    assign g10 = {g_q, 2'b00};
    assign r10 = {data_i, 2'b00};

    // ---------------- Phase FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= StWaitB;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (resync_i || timeout_fire) begin
            phase_d = StWaitB;
        end else if (accept) begin
            unique case (phase_q)
                StWaitB: phase_d = StWaitG;
                StWaitG: phase_d = StWaitR;
                default: phase_d = StWaitB;
            endcase
        end
    end

    always_comb begin
        wr_o         = pend_q & ~wr_full_i;
        frame_done_o = wr_o & (pos_q == PosLast);
    end

    // ---------------- Datapath ----------------
    always_comb begin
        b_d         = b_q;
        g_d         = g_q;
        pend_d      = pend_q;
        wr1_d       = wr1_q;
        wr2_d       = wr2_q;
        pos_d       = pos_q;
        pix_cnt_d   = pix_cnt_q;
        frame_cnt_d = frame_cnt_q;
        overflow_d  = overflow_q;

        if (accept && phase_q == StWaitB) b_d = data_i;
        if (accept && phase_q == StWaitG) g_d = data_i;

        if (wr_o) begin
            pend_d    = 1'b0;
            pix_cnt_d = pix_cnt_q + 32'd1;
            if (pos_q == PosLast) begin
                pos_d       = '0;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                pos_d = pos_q + PosW'(1);
            end
        end

        if (load_pix) begin
            pend_d = 1'b1;
            wr1_d  = {1'b0, g10[9:5], b10};
            wr2_d  = {1'b0, g10[4:0], r10};
        end
        if (drop_pix) overflow_d = 1'b1;

        if (resync_i) begin
            pend_d     = 1'b0;
            pos_d      = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            write_q     <= 1'b0;
            b_q         <= '0;
            g_q         <= '0;
            pend_q      <= 1'b0;
            wr1_q       <= '0;
            wr2_q       <= '0;
            pos_q       <= '0;
            pix_cnt_q   <= '0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            write_q     <= write_i;
            b_q         <= b_d;
            g_q         <= g_d;
            pend_q      <= pend_d;
            wr1_q       <= wr1_d;
            wr2_q       <= wr2_d;
            pos_q       <= pos_d;
            pix_cnt_q   <= pix_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign wr1_data_o  = wr1_q;
    assign wr2_data_o  = wr2_q;
    assign pix_cnt_o   = pix_cnt_q;
    assign frame_cnt_o = frame_cnt_q;
    assign overflow_o  = overflow_q;

    // ---------------- Optional partial-pixel timeout ----------------
`ifdef PACKER_TIMEOUT_EN
    localparam int unsigned IdleW = (TimeoutCyc > 1) ? $clog2(TimeoutCyc) : 1;

    logic [IdleW-1:0] idle_q, idle_d;
    logic             timeout_q;

    always_comb begin
        idle_d       = idle_q;
        timeout_fire = 1'b0;
        if (resync_i || accept || phase_q == StWaitB) begin
            idle_d = '0;
        end else if (idle_q == IdleW'(TimeoutCyc - 1)) begin
            idle_d       = '0;
            timeout_fire = 1'b1;
        end else begin
            idle_d = idle_q + IdleW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_fire;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_fire = 1'b0;
    assign timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Self-checking bench for uart_pixel_packer: vector table, directed corner cases and
// randomized byte streams with bursty back-pressure against a byte-queue reference model.
module tb_uart_pixel_packer;

    localparam int unsigned HRes      = 4;
    localparam int unsigned VRes      = 2;
    localparam int unsigned FrameSize = HRes * VRes;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic        write_i = 1'b0;
    logic        resync_i = 1'b0;
    logic        wr_full_i;
    logic [15:0] wr1_data_o;
    logic [15:0] wr2_data_o;
    logic        wr_o;
    logic [31:0] pix_cnt_o;
    logic [15:0] frame_cnt_o;
    logic        frame_done_o;
    logic        overflow_o;
    logic        timeout_o;

    logic full_force = 1'b0;
    logic full_rand  = 1'b0;
    logic rand_en    = 1'b0;
    assign wr_full_i = full_force | (rand_en & full_rand);

    uart_pixel_packer #(
        .HRes       (HRes),
        .VRes       (VRes),
        .TimeoutCyc (100)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .data_i       (data_i),
        .write_i      (write_i),
        .resync_i     (resync_i),
        .wr_full_i    (wr_full_i),
        .wr1_data_o   (wr1_data_o),
        .wr2_data_o   (wr2_data_o),
        .wr_o         (wr_o),
        .pix_cnt_o    (pix_cnt_o),
        .frame_cnt_o  (frame_cnt_o),
        .frame_done_o (frame_done_o),
        .overflow_o   (overflow_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    // Observed writes: {frame_done, wr1, wr2}
    logic [32:0] mon_q[$];
    int          to_cnt = 0;

    always @(negedge clk_i) begin
        if (rst_ni && wr_o) mon_q.push_back({frame_done_o, wr1_data_o, wr2_data_o});
        if (rst_ni && timeout_o) to_cnt++;
    end

    // Reference model state
    int exp_pix   = 0;
    int exp_frame = 0;
    int exp_pos   = 0;

    typedef struct {
        logic [7:0]  b;
        logic [7:0]  g;
        logic [7:0]  r;
        logic [15:0] w1;
        logic [15:0] w2;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [31:0] pack(input int b, input int g, input int r);
        int w1;
        int w2;
        w1 = ((g * 4) / 32) * 1024 + b * 4;
        w2 = ((g * 4) % 32) * 1024 + r * 4;
        return {w1[15:0], w2[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(posedge clk_i);
        #1;
        data_i  = b;
        write_i = 1'b1;
        repeat (hold) @(posedge clk_i);
        #1;
        write_i = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
        send_byte(b, 1);
        send_byte(g, 1);
        send_byte(r, 1);
    endtask

    task automatic expect_pixel(input string name, input logic [15:0] e1, input logic [15:0] e2);
        int          waited;
        logic [32:0] ent;
        logic        fd_exp;
        waited = 0;
        while (mon_q.size() == 0 && waited < 40) begin
            @(negedge clk_i);
            waited++;
        end
        if (mon_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no write within 40 cycles, expected 0x%0h/0x%0h", name, e1, e2);
            return;
        end
        ent    = mon_q.pop_front();
        fd_exp = (exp_pos == FrameSize - 1);
        check({name, " wr1"}, {16'h0, ent[31:16]}, {16'h0, e1});
        check({name, " wr2"}, {16'h0, ent[15:0]}, {16'h0, e2});
        check({name, " frame_done"}, {31'h0, ent[32]}, {31'h0, fd_exp});
        exp_pix++;
        if (fd_exp) begin
            exp_pos = 0;
            exp_frame++;
        end else begin
            exp_pos++;
        end
    endtask

    task automatic check_counts(input string name);
        check({name, " pix_cnt"}, pix_cnt_o, exp_pix);
        check({name, " frame_cnt"}, {16'h0, frame_cnt_o}, exp_frame);
    endtask

    task automatic check_idle(input string name, input int cycles);
        repeat (cycles) @(negedge clk_i);
        check({name, " no extra write"}, mon_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        exp_pix   = 0;
        exp_frame = 0;
        exp_pos   = 0;
        mon_q.delete();
    endtask

    task automatic do_resync();
        @(posedge clk_i);
        #1;
        resync_i = 1'b1;
        @(posedge clk_i);
        #1;
        resync_i = 1'b0;
        exp_pos = 0;
    endtask

    // Bursty back-pressure: at most 3 busy cycles, always followed by a free one.
    initial begin
        int len;
        forever begin
            @(posedge clk_i);
            #1;
            if (rand_en && !full_rand && $urandom_range(0, 3) == 0) begin
                full_rand = 1'b1;
                len = $urandom_range(1, 3);
                repeat (len) @(posedge clk_i);
                #1 full_rand = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pw;
        logic [31:0] exp_list[$];
        int          to_before;

        vecs[0] = '{b: 8'h12, g: 8'h34, r: 8'h56, w1: 16'h1848, w2: 16'h4158};
        vecs[1] = '{b: 8'hFF, g: 8'hFF, r: 8'hFF, w1: 16'h7FFC, w2: 16'h73FC};
        vecs[2] = '{b: 8'h00, g: 8'h00, r: 8'h00, w1: 16'h0000, w2: 16'h0000};
        vecs[3] = '{b: 8'h80, g: 8'h01, r: 8'hFF, w1: 16'h0200, w2: 16'h13FC};
        vecs[4] = '{b: 8'hA5, g: 8'h5A, r: 8'hC3, w1: 16'h2E94, w2: 16'h230C};

        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("reset wr", {31'h0, wr_o}, 0);
        check("reset pix_cnt", pix_cnt_o, 0);
        check("reset frame_cnt", {16'h0, frame_cnt_o}, 0);
        check("reset overflow", {31'h0, overflow_o}, 0);
        check("reset timeout", {31'h0, timeout_o}, 0);
        check("reset wr1", {16'h0, wr1_data_o}, 0);

        for (int i = 0; i < 5; i++) begin
            send_pix(vecs[i].b, vecs[i].g, vecs[i].r);
            expect_pixel($sformatf("vec%0d", i), vecs[i].w1, vecs[i].w2);
            check_counts($sformatf("vec%0d", i));
        end

        // Long-held strobe counts as a single byte
        send_byte(8'hFF, 10);
        send_byte(8'hFF, 1);
        check_idle("held strobe partial", 4);
        send_byte(8'hFF, 1);
        expect_pixel("held strobe", 16'h7FFC, 16'h73FC);
        check_idle("held strobe", 10);
        check_counts("held strobe");

        // Back-pressure: second completed pixel is dropped
        do_resync();
        full_force = 1'b1;
        send_pix(8'h12, 8'h34, 8'h56);
        send_pix(8'h01, 8'h02, 8'h03);
        check_idle("full hold", 3);
        check("overflow set", {31'h0, overflow_o}, 1);
        full_force = 1'b0;
        expect_pixel("full release", 16'h1848, 16'h4158);
        check_idle("dropped pixel", 8);
        check_counts("after drop");
        check("overflow sticky", {31'h0, overflow_o}, 1);
        do_resync();
        @(negedge clk_i);
        check("overflow cleared", {31'h0, overflow_o}, 0);

        // Resync discards a partial pixel
        send_byte(8'h77, 1);
        send_byte(8'h66, 1);
        do_resync();
        send_pix(8'hA5, 8'h5A, 8'hC3);
        expect_pixel("after resync", 16'h2E94, 16'h230C);
        check_counts("after resync");

        // Idle partial pixel
        to_before = to_cnt;
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        repeat (110) @(negedge clk_i);
`ifdef PACKER_TIMEOUT_EN
        check("timeout pulses", to_cnt - to_before, 1);
        send_pix(8'h33, 8'h44, 8'h55);
        pw = pack(8'h33, 8'h44, 8'h55);
        expect_pixel("post timeout", pw[31:16], pw[15:0]);
`else
        check("timeout pulses", to_cnt - to_before, 0);
        send_byte(8'h33, 1);
        pw = pack(8'h11, 8'h22, 8'h33);
        expect_pixel("no timeout", pw[31:16], pw[15:0]);
        send_byte(8'h44, 1);
        send_byte(8'h55, 1);
        do_resync();
`endif
        check_idle("timeout section", 5);

        // Reset mid-pixel
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        do_reset();
        @(negedge clk_i);
        check_counts("after reset");
        send_pix(8'hA5, 8'h5A, 8'hC3);
        expect_pixel("reset mid-pixel", 16'h2E94, 16'h230C);
        check_counts("reset mid-pixel");

        // Frame wrap: 9 pixels on a 4x2 frame
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send_pix(8'(i * 3), 8'(i * 3 + 1), 8'(i * 3 + 2));
            pw = pack(i * 3, i * 3 + 1, i * 3 + 2);
            expect_pixel($sformatf("frame px%0d", i), pw[31:16], pw[15:0]);
        end
        check("frame_cnt after 9", {16'h0, frame_cnt_o}, 1);
        check("pix_cnt after 9", pix_cnt_o, 9);

        // Random bytes, strobe lengths, gaps and back-pressure
        do_resync();
        rand_en = 1'b1;
        for (int p = 0; p < 60; p++) begin
            logic [7:0] bb;
            logic [7:0] gg;
            logic [7:0] rr;
            bb = 8'($urandom_range(0, 255));
            gg = 8'($urandom_range(0, 255));
            rr = 8'($urandom_range(0, 255));
            exp_list.push_back(pack(bb, gg, rr));
            send_byte(bb, $urandom_range(1, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            send_byte(gg, $urandom_range(1, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            send_byte(rr, $urandom_range(1, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
        end
        repeat (6) @(posedge clk_i);
        rand_en = 1'b0;
        for (int p = 0; p < 60; p++) begin
            pw = exp_list.pop_front();
            expect_pixel($sformatf("rand px%0d", p), pw[31:16], pw[15:0]);
        end
        check_idle("random", 5);
        check_counts("random");
        check("random overflow", {31'h0, overflow_o}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
